uart_rx_oversampled: RTL and testbench
======================================

Name: uart_rx_oversampled

Overview:
- UART receiver that consumes the 16x oversampling tick from the baud tick generator and deserialises 8N1-style frames from the rx pin.
- Sits directly downstream of the baud tick generator. Delivers bytes to the SHA-256 message loader / RX FIFO as a one-cycle done strobe plus a data word.
- Mid-bit sampling. Framing-error detection. Start-bit glitch rejection.

Parameters:
- DBITS, 8, number of data bits per frame, LSB first.
- SB_TICK, 16, oversample ticks spent in the stop bit (16 = 1 stop bit, 24 = 1.5, 32 = 2).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- rx  input  1  asynchronous serial line, idle high.
- s_tick  input  1  one-clk pulse at 16x baud, from the baud tick generator.
- dout  output  DBITS  last received data word.
- rx_done_tick  output  1  one-clk pulse: frame complete, dout/frame_err valid.
- frame_err  output  1  stop bit sampled low on the last frame.
- parity_err  output  1  parity mismatch on the last frame (see Optional Feature).

Behaviour:
- Reset (synchronous, active-high, evaluated on the clk rising edge):
  - state=IDLE; s and n counters 0; shift register 0.
  - dout=0, rx_done_tick=0, frame_err=0, parity_err=0.
  - Synchroniser flops preset to 1.
- rx passes through a 2-flop synchroniser (rx_s), plus one delay flop (rx_d) for edge detection. Pin-to-FSM latency is 2 clk.
- Counters:
  - s is 4 bits (5 bits if SB_TICK>16) and counts s_tick pulses.
  - n is clog2(DBITS) bits and counts data bits.
  - Counters advance only in cycles where s_tick=1.
- States:
  - IDLE: a falling edge (rx_d=1 and rx_s=0) moves to START with s=0. rx held low with no edge (break, or line stuck after an error) does not start a frame.
  - START: on s_tick with s==7 (bit centre): if rx_s==0, go to DATA with s=0, n=0. Otherwise the start was a glitch; return to IDLE with no strobe. On other ticks, s++.
  - DATA: on s_tick with s==15, set s=0 and shift right, inserting rx_s at the MSB (LSB-first assembly). If n==DBITS-1, go to STOP (or PARITY when enabled); else n++. On other ticks, s++.
  - STOP: on s_tick with s==SB_TICK-1:
    - dout takes the shift register;
    - frame_err takes ~rx_s;
    - rx_done_tick=1 for exactly one clk;
    - state returns to IDLE.
    - On other ticks, s++.
- Outputs are registered. rx_done_tick rises on the clk edge after the qualifying s_tick cycle.
- dout, frame_err and parity_err hold their values until the next rx_done_tick.
- A frame error still produces rx_done_tick; the consumer decides whether to drop the byte.
- s_tick asserted in consecutive clks is legal; each pulse counts.
- With s_tick held 0, the FSM freezes in its current state.
- Reset asserted mid-frame aborts immediately with no strobe. A line already low when reset releases is ignored until the next falling edge.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP and lasts 16 ticks. The bit is sampled at s==15.
  - parity_err = sampled bit XOR (XOR of the data bits), i.e. even parity.
  - parity_err updates together with dout on rx_done_tick.
- Undefined:
  - No PARITY state; DATA goes straight to STOP.
  - parity_err is tied to 0.
  - The port is always present, so the interface is identical in both builds.

Test Plan:
- Setup for every test: s_tick every 4 clk. Bit period = 64 clk.
- Basic frame: send 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1).
  - Exactly one rx_done_tick, about 10 bit periods after the falling edge.
  - dout=0xA5, frame_err=0.
- Back-to-back: 0x00 immediately followed by 0xFF with no idle gap.
  - Two strobes; dout=0x00 then 0xFF; frame_err=0 both times.
- Glitch: rx low for 4 ticks, then high.
  - No rx_done_tick; FSM back in IDLE.
  - A following 0x3C frame is received correctly.
- Frame error: send 0x3C with stop bit 0, then hold rx low for 3 bit periods, then high.
  - One strobe with dout=0x3C, frame_err=1.
  - No further strobe while the line stays low.
  - The next valid frame 0x11 gives frame_err=0.
- Reset mid-frame: assert reset for 1 clk during data bit 4.
  - No strobe; outputs=0.
  - The next 0x5A frame is received with dout=0x5A.
- Parity (UART_RX_PARITY_EN defined):
  - 0x07 with parity bit 1 gives parity_err=0.
  - 0x07 with parity bit 0 gives parity_err=1.
  - Undefined build: parity_err stays 0 throughout.

Source files
------------

// File: rtl/uart_rx_oversampled.sv
// 8N1-style UART receiver driven by a 16x oversampling tick; mid-bit sampling,
// start-glitch rejection, framing check. Define UART_RX_PARITY_EN for an even-parity bit.
`timescale 1ns/1ps
module uart_rx_oversampled #(
  parameter int DBITS   = 8,
  parameter int SB_TICK = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx,
  input  logic             s_tick,
  output logic [DBITS-1:0] dout,
  output logic             rx_done_tick,
  output logic             frame_err,
  output logic             parity_err
);

  localparam int SW = (SB_TICK > 16) ? 5 : 4;
  localparam int NW = (DBITS > 1) ? $clog2(DBITS) : 1;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] STOP   = 3'd3;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd4;
  logic pbit;
`endif

  logic [2:0]       state;
  logic [SW-1:0]    s;
  logic [NW-1:0]    n;
  logic [DBITS-1:0] b;
  logic             rx_meta, rx_s, rx_d;

  // Synchroniser presets to the idle level so a reset never fakes a falling edge.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_d    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_d    <= rx_s;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      s            <= '0;
      n            <= '0;
      b            <= '0;
      dout         <= '0;
      rx_done_tick <= 1'b0;
      frame_err    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      pbit         <= 1'b0;
      parity_err   <= 1'b0;
`endif
    end else begin
      rx_done_tick <= 1'b0;
      case (state)
        IDLE: begin
          // Edge-triggered start: a line held low never launches a frame.
          if (rx_d && !rx_s) begin
            state <= START;
            s     <= '0;
          end
        end
        START: begin
          if (s_tick) begin
            if (s == SW'(7)) begin
              if (!rx_s) begin
                state <= DATA;
                s     <= '0;
                n     <= '0;
              end else begin
                state <= IDLE;
              end
            end else begin
              s <= s + SW'(1);
            end
          end
        end
        DATA: begin
          if (s_tick) begin
            if (s == SW'(15)) begin
              s <= '0;
              b <= {rx_s, b[DBITS-1:1]};
              if (n == NW'(DBITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end else begin
                n <= n + NW'(1);
              end
            end else begin
              s <= s + SW'(1);
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (s_tick) begin
            if (s == SW'(15)) begin
              s     <= '0;
              pbit  <= rx_s;
              state <= STOP;
            end else begin
              s <= s + SW'(1);
            end
          end
        end
`endif
        STOP: begin
          if (s_tick) begin
            if (s == SW'(SB_TICK - 1)) begin
              dout         <= b;
              frame_err    <= ~rx_s;
              rx_done_tick <= 1'b1;
`ifdef UART_RX_PARITY_EN
              parity_err   <= pbit ^ (^b);
`endif
              state        <= IDLE;
            end else begin
              s <= s + SW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef UART_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Directed bench for uart_rx_oversampled: s_tick every 4 clk, 64-clk bit period.
// Honours UART_RX_PARITY_EN to send/check a parity bit.
`timescale 1ns/1ps
module tb_uart_rx_oversampled;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       s_tick = 1'b0;
  logic [7:0] dout;
  logic       rx_done_tick, frame_err, parity_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int fall_cyc = 0;
  logic [7:0] last_dout = '0;
  logic last_fe = 1'b0, last_pe = 1'b0;
  logic any_pe = 1'b0, wide_strobe = 1'b0, prev_done = 1'b0;
  logic [1:0] tcnt = '0;
  int base;

`ifdef UART_RX_PARITY_EN
  localparam int LAT_LO = 664, LAT_HI = 689;
`else
  localparam int LAT_LO = 600, LAT_HI = 625;
`endif

  uart_rx_oversampled #(.DBITS(8), .SB_TICK(16)) dut (
    .clk(clk), .reset(reset), .rx(rx), .s_tick(s_tick),
    .dout(dout), .rx_done_tick(rx_done_tick),
    .frame_err(frame_err), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    tcnt = tcnt + 2'd1;
    s_tick = (tcnt == 2'd3);
  end

  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (rx_done_tick) begin
      done_cnt  = done_cnt + 1;
      done_cyc  = cyc;
      last_dout = dout;
      last_fe   = frame_err;
      last_pe   = parity_err;
      if (prev_done) wide_strobe = 1'b1;
    end
    if (parity_err) any_pe = 1'b1;
    prev_done = rx_done_tick;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic v, input int clks);
    rx = v;
    repeat (clks) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic bad_par);
    @(negedge clk);
    fall_cyc = cyc;
    hold(1'b0, 64);
    for (int i = 0; i < 8; i++) hold(d[i], 64);
`ifdef UART_RX_PARITY_EN
    hold((^d) ^ bad_par, 64);
`else
    if (bad_par) hold(1'b1, 0);
`endif
    hold(stop, 64);
    rx = 1'b1;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_dout", 32'(dout), 32'h0);
    check("reset_done", 32'(rx_done_tick), 32'h0);
    check("reset_fe", 32'(frame_err), 32'h0);
    check("reset_pe", 32'(parity_err), 32'h0);
    hold(1'b1, 100);

    // Basic frame
    base = done_cnt;
    send_frame(8'hA5, 1'b1, 1'b0);
    hold(1'b1, 20);
    check("basic_count", 32'(done_cnt - base), 32'd1);
    check("basic_dout", 32'(last_dout), 32'hA5);
    check("basic_fe", 32'(last_fe), 32'h0);
    check("basic_latency", 32'((done_cyc - fall_cyc >= LAT_LO) && (done_cyc - fall_cyc <= LAT_HI)), 32'h1);

    // Back-to-back, no idle gap
    base = done_cnt;
    send_frame(8'h00, 1'b1, 1'b0);
    check("b2b_first_dout", 32'(last_dout), 32'h00);
    check("b2b_first_fe", 32'(last_fe), 32'h0);
    send_frame(8'hFF, 1'b1, 1'b0);
    hold(1'b1, 20);
    check("b2b_count", 32'(done_cnt - base), 32'd2);
    check("b2b_second_dout", 32'(last_dout), 32'hFF);
    check("b2b_second_fe", 32'(last_fe), 32'h0);

    // Start glitch (4 ticks low)
    base = done_cnt;
    hold(1'b0, 16);
    hold(1'b1, 200);
    check("glitch_no_strobe", 32'(done_cnt - base), 32'd0);
    send_frame(8'h3C, 1'b1, 1'b0);
    hold(1'b1, 20);
    check("glitch_next_count", 32'(done_cnt - base), 32'd1);
    check("glitch_next_dout", 32'(last_dout), 32'h3C);

    // Framing error, then line stuck low
    base = done_cnt;
    send_frame(8'h3C, 1'b0, 1'b0);
    hold(1'b0, 3 * 64);
    check("ferr_count", 32'(done_cnt - base), 32'd1);
    check("ferr_dout", 32'(last_dout), 32'h3C);
    check("ferr_fe", 32'(last_fe), 32'h1);
    hold(1'b1, 100);
    check("ferr_low_no_strobe", 32'(done_cnt - base), 32'd1);
    send_frame(8'h11, 1'b1, 1'b0);
    hold(1'b1, 20);
    check("ferr_next_dout", 32'(last_dout), 32'h11);
    check("ferr_next_fe", 32'(last_fe), 32'h0);

    // Reset during data bit 4 (line high from bit 4 onward, no later edge)
    base = done_cnt;
    hold(1'b0, 5 * 64);
    hold(1'b1, 32);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    hold(1'b1, 6 * 64);
    check("rst_no_strobe", 32'(done_cnt - base), 32'd0);
    check("rst_dout", 32'(dout), 32'h0);
    check("rst_fe", 32'(frame_err), 32'h0);
    check("rst_pe", 32'(parity_err), 32'h0);
    send_frame(8'h5A, 1'b1, 1'b0);
    hold(1'b1, 20);
    check("rst_next_count", 32'(done_cnt - base), 32'd1);
    check("rst_next_dout", 32'(last_dout), 32'h5A);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0);
    hold(1'b1, 20);
    check("par_good_dout", 32'(last_dout), 32'h07);
    check("par_good_pe", 32'(last_pe), 32'h0);
    send_frame(8'h07, 1'b1, 1'b1);
    hold(1'b1, 20);
    check("par_bad_dout", 32'(last_dout), 32'h07);
    check("par_bad_pe", 32'(last_pe), 32'h1);
`else
    send_frame(8'h07, 1'b1, 1'b0);
    hold(1'b1, 20);
    check("nopar_dout", 32'(last_dout), 32'h07);
    check("nopar_pe_never", 32'(any_pe), 32'h0);
`endif
    check("strobe_one_clk", 32'(wide_strobe), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
